// File: rtl/alu_mdu_iter_pkg.sv
// Shared encodings for the execute-stage ALU/MDU: base ALU control codes,
// RV32M funct3 values and the top-level handshake state.
package alu_mdu_iter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/alu_mdu_iter_core.sv
// Unsigned shift-add multiplier / restoring divider on operand magnitudes.
// acc is the post-iteration value, so the caller can register it on the done cycle.
module alu_mdu_iter_core
    import alu_mdu_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic              done,
    output logic [2*XLEN-1:0] acc
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d, div_q, div_d;
    logic [XLEN:0]   sum, shl;

    assign done = run_q && (cnt_q == CW'(XLEN - 1));
    assign acc  = {hi_d, lo_d};

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        div_d = div_q;
        sum   = {1'b0, hi_q} + {1'b0, lo_q[0] ? dvs_q : {XLEN{1'b0}}};
        shl   = {hi_q, lo_q[XLEN-1]};
        if (start) begin
            hi_d  = '0;
            lo_d  = opa;
            dvs_d = opb;
            div_d = is_div;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            run_d = !done;
            if (div_q) begin
                // hi holds the partial remainder, lo shifts dividend out and quotient in
                if (shl >= {1'b0, dvs_q}) begin
                    hi_d = XLEN'(shl - {1'b0, dvs_q});
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = shl[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_mdu_iter.sv
// Execute-stage ALU plus RV32M multiply/divide with valid/ready on both sides.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle combinational multiply; divide stays iterative.
module alu_mdu_iter
    import alu_mdu_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            is_zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              core_start, core_done;
    logic [2*XLEN-1:0] core_acc;
    logic [XLEN-1:0]   alu_res, mag_a, mag_b;
    logic [SHW-1:0]    shamt;
    logic              a_sgn, b_sgn, sa, sb, div_by0, div_ovf;

    // Signs are applied after the unsigned datapath; unsigned ops carry sa=sb=0.
    function automatic logic [XLEN-1:0] fixup(input logic [2:0] f3, input logic fsa,
                                              input logic fsb, input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem;
        prod = (fsa ^ fsb) ? -acc : acc;
        quo  = (fsa ^ fsb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = fsa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            MDU_MUL:                         fixup = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fixup = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fixup = quo;
            MDU_REM, MDU_REMU:               fixup = rem;
            default:                         fixup = '0;
        endcase
    endfunction

    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op[3:0])
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            ALU_LUI:  alu_res = b;
            default:  alu_res = '0;
        endcase
    end

    assign a_sgn   = (op[2:0] == MDU_MULH) || (op[2:0] == MDU_MULHSU) ||
                     (op[2:0] == MDU_DIV)  || (op[2:0] == MDU_REM);
    assign b_sgn   = (op[2:0] == MDU_MULH) || (op[2:0] == MDU_DIV) || (op[2:0] == MDU_REM);
    assign sa      = a_sgn & a[XLEN-1];
    assign sb      = b_sgn & b[XLEN-1];
    assign mag_a   = sa ? -a : a;
    assign mag_b   = sb ? -b : b;
    assign div_by0 = op[2] && (b == '0);
    assign div_ovf = op[2] && !op[0] && (a == XMIN) && (b == {XLEN{1'b1}});

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        f3_d       = f3_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = DONE;
                f3_d    = op[2:0];
                sa_d    = sa;
                sb_d    = sb;
                if (!op[4])       result_d = alu_res;
                else if (div_by0) result_d = op[1] ? a : {XLEN{1'b1}};
                else if (div_ovf) result_d = op[1] ? {XLEN{1'b0}} : XMIN;
`ifdef ALU_MDU_FAST_MUL_EN
                else if (!op[2])  result_d = fixup(op[2:0], sa, sb, fast_prod);
`endif
                else begin
                    core_start = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: if (core_done) begin
                state_d  = DONE;
                result_d = fixup(f3_q, sa_q, sb_q, core_acc);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
        end
    end

    alu_mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .is_div (op[2]),
        .opa    (mag_a),
        .opb    (mag_b),
        .done   (core_done),
        .acc    (core_acc)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign is_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Randomized scoreboard bench for alu_mdu_iter (XLEN=32) with directed corner cases.
module tb_alu_mdu_iter;

    localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        is_zero;
    logic        busy;

    alu_mdu_iter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .is_zero(is_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   seen = 0;
    logic rdy_force = 1'b1, rdy_val = 1'b1;
    logic [4:0] op_tab [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: observed 0x%08h, required no such event", nm, act);
    endtask

    // Reference: plain arithmetic from the instruction semantics.
    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[4]) begin
            case (o[3:0])
                4'h0: return x + y;
                4'h8: return x - y;
                4'h7: return x & y;
                4'h6: return x | y;
                4'h4: return x ^ y;
                4'h2: return (sx < sy) ? 32'd1 : 32'd0;
                4'h3: return (x < y) ? 32'd1 : 32'd0;
                4'h1: return x << y[4:0];
                4'h5: return x >> y[4:0];
                4'hD: return $unsigned($signed(x) >>> y[4:0]);
                4'hE: return y;
                default: return 32'd0;
            endcase
        end
        case (o[2:0])
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * longint'({32'b0, y})); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
                return 32'(sx / sy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[4]) return 1;
        if (!o[2]) return MUL_LAT;
        if (y == 0) return 1;
        if (!o[0] && x == MIN && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] req, input int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_timeout", {31'b0, in_ready});
            return;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back('{op: o, res: req, acc: cyc, lat: lat});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, ref_res(o, x, y), ref_lat(o, x, y));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom % 16);
            4: return -32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout", 32'(exp_q.size()));
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_force ? rdy_val : (($urandom % 4) != 0);
    end

    // Monitor: latency on first valid cycle, result held on every valid cycle, pop on handshake.
    initial forever begin
        @(negedge clk);
        if (rst) seen = 0;
        else if (out_valid) begin
            if (exp_q.size() == 0) fail_now("spurious_out", result);
            else begin
                e = exp_q[0];
                if (seen == 0) begin
                    chk($sformatf("latency op=%02h", e.op), 32'(cyc - e.acc), 32'(e.lat));
                    seen = 1;
                end
                chk($sformatf("result op=%02h", e.op), result, e.res);
                chk($sformatf("is_zero op=%02h", e.op), {31'b0, is_zero}, {31'b0, e.res == 32'd0});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        op_tab = '{5'h00, 5'h08, 5'h07, 5'h06, 5'h04, 5'h02, 5'h03, 5'h01, 5'h05, 5'h0D,
                   5'h0E, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_is_zero", {31'b0, is_zero}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed values with hand-computed results
        issue(5'h00, 32'd7, 32'hFFFF_FFFD, 32'd4, 1);
        issue(5'h08, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        issue(5'h0D, MIN, 32'd4, 32'hF800_0000, 1);
        issue(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT);
        issue(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
        issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        issue(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        issue(5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        issue(5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        issue(5'h15, 32'd100, 32'd7, 32'd14, 33);
        issue(5'h17, 32'd100, 32'd7, 32'd2, 33);
        issue(5'h16, 32'd8, 32'd4, 32'd0, 33);
        issue(5'h14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        issue(5'h16, 32'd5, 32'd0, 32'd5, 1);
        issue(5'h14, MIN, 32'hFFFF_FFFF, MIN, 1);
        issue(5'h16, MIN, 32'hFFFF_FFFF, 32'd0, 1);
        wait_drain();

        // backpressure: result held, new requests ignored while DONE
        rdy_val = 1'b0;
        issue(5'h00, 32'd1, 32'd2, 32'd3, 1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin @(negedge clk); n++; end
        end
        repeat (10) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 5'h00; a = $urandom; b = $urandom;
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_val = 1'b1;
        wait_drain();

        // reset during the 10th iteration aborts the multiply with no output
        issue(5'h13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, MUL_LAT);
        repeat (10) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        issue(5'h00, 32'd1, 32'd1, 32'd2, 1);
        wait_drain();

        // random traffic with random consumer stalls
        rdy_force = 1'b0;
        for (int i = 0; i < 200; i++) begin
            run_op(op_tab[$urandom % 20], rnd_val(), rnd_val());
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
